hilo_div_unit: RTL and testbench

//  Owns the architectural HI/LO register pair and the multi-cycle DIV/DIVU engine.
//  - The ALU produces the MULT/MULTU/MTHI/MTLO results as a 64-bit {hi,lo} value plus a write enable; this block receives them.
//  - It feeds the current hi_o/lo_o values back to the ALU for MFHI/MFLO.
//  - It stalls the pipeline while a divide is in flight.

---
 rtl/hilo_div_unit_pkg.sv | 17 +
 rtl/hilo_div_if.sv | 34 +++
 rtl/hilo_div_unit_div_core.sv | 52 +++++
 rtl/hilo_div_unit.sv | 109 ++++++++++
 tb/tb_hilo_div_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_div_unit_pkg.sv
// Shared types and constants for the HI/LO register pair and divide engine.
`timescale 1ns/1ps
package hilo_div_unit_pkg;

  localparam int DATA_W = 32;

  // Function-field encodings of the two divide instructions.
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/hilo_div_if.sv
// Pipeline-side bundle for the HI/LO and divide unit; master = pipeline/ALU, slave = unit.
`timescale 1ns/1ps
interface hilo_div_if #(
  parameter int WIDTH = 32
) ();
  import hilo_div_unit_pkg::*;

  // Handshake: div_start is a request taken only in IDLE/DONE with flush low.
  // stall_o is the busy indication (combinational in the start cycle), and
  // div_done pulses for one cycle once the result is readable on hi_o/lo_o.
  logic               hilo_we;
  logic [2*WIDTH-1:0] hilo_i;
  logic               div_start;
  logic               div_signed;
  logic [WIDTH-1:0]   div_a;
  logic [WIDTH-1:0]   div_b;
  logic               flush;
  logic               stall_o;
  logic               div_done;
  logic [WIDTH-1:0]   hi_o;
  logic [WIDTH-1:0]   lo_o;
  div_state_e         state;

  modport master (
    output hilo_we, hilo_i, div_start, div_signed, div_a, div_b, flush,
    input  stall_o, div_done, hi_o, lo_o, state
  );

  modport slave (
    input  hilo_we, hilo_i, div_start, div_signed, div_a, div_b, flush,
    output stall_o, div_done, hi_o, lo_o, state
  );

endinterface

// File: rtl/hilo_div_unit_div_core.sv
// Unsigned restoring divider datapath: one shift-subtract step per cycle.
`timescale 1ns/1ps
module hilo_div_unit_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] r_next,
  output logic             last
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic [5:0]       count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  assign r_shift = {r_reg, q_reg[WIDTH-1]};
  assign ge      = (r_shift >= {1'b0, d_reg});
  assign diff    = r_shift[WIDTH-1:0] - d_reg;
  assign r_next  = ge ? diff : r_shift[WIDTH-1:0];
  assign q_next  = {q_reg[WIDTH-2:0], ge};
  assign last    = (count == 6'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
      r_reg <= '0;
      d_reg <= '0;
      count <= '0;
    end else if (load) begin
      q_reg <= dividend;
      r_reg <= '0;
      d_reg <= divisor;
      count <= '0;
    end else if (step) begin
      q_reg <= q_next;
      r_reg <= r_next;
      count <= count + 6'd1;
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO architectural registers plus the DIV/DIVU sequencer, sign fix-up and flush handling.
`timescale 1ns/1ps
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  hilo_div_if.slave bus
);

  div_state_e       state;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             qneg_q;
  logic             rneg_q;

  logic             accept_state;
  logic             start_go;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             core_load;
  logic             core_step;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;
  logic             core_last;

  assign accept_state = (state == ST_IDLE) || (state == ST_DONE);
  assign start_go     = accept_state && bus.div_start && !bus.flush && !rst;

  assign a_neg  = bus.div_signed && bus.div_a[WIDTH-1];
  assign b_neg  = bus.div_signed && bus.div_b[WIDTH-1];
  assign a_mag  = a_neg ? -bus.div_a : bus.div_a;
  assign b_mag  = b_neg ? -bus.div_b : bus.div_b;
  assign b_zero = (bus.div_b == '0);

  assign core_load = start_go && !b_zero;
  assign core_step = (state == ST_DIV) && !bus.flush;

  hilo_div_unit_div_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .q_next   (core_q),
    .r_next   (core_r),
    .last     (core_last)
  );

  assign bus.stall_o  = (state == ST_DIV) || start_go;
  assign bus.div_done = done_q;
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;
  assign bus.state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (bus.hilo_we) begin
            hi_q <= bus.hilo_i[2*WIDTH-1:WIDTH];
            lo_q <= bus.hilo_i[WIDTH-1:0];
          end
          // A divide started alongside an ALU write overwrites it later (or now, for /0).
          if (start_go) begin
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            if (b_zero) begin
              hi_q   <= bus.div_a;
              lo_q   <= '1;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else if (core_last) begin
            lo_q   <= qneg_q ? -core_q : core_q;
            hi_q   <= rneg_q ? -core_r : core_r;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: divide results go through an expected queue checked on div_done.
`timescale 1ns/1ps
module tb_hilo_div_unit;

  logic clk;
  logic rst;

  hilo_div_if #(.WIDTH(32)) bus ();

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total;
  int bad;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor();
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.div_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_hi", {32'd0, bus.hi_o}, {32'd0, e[63:32]});
          check("sb_lo", {32'd0, bus.lo_o}, {32'd0, e[31:0]});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.hilo_we    = 1'b0;
    bus.hilo_i     = '0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_a      = '0;
    bus.div_b      = '0;
    bus.flush      = 1'b0;
  endtask

  // Called #1 after a posedge with div_start already driven; cyc=0 is the current cycle.
  // Returns at the negedge where div_done is seen (or once the budget runs out).
  task automatic wait_done(output int cyc, output int stall_n, output bit seen);
    stall_n = 0;
    seen    = 0;
    cyc     = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (bus.div_done) begin
        seen = 1;
      end else begin
        if (bus.stall_o) stall_n++;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        bus.hilo_we   = 1'b0;
        cyc++;
      end
    end
    if (!seen) check("div_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int  cyc;
    int  stall_n;
    bit  seen;
    bus.div_start  = 1'b1;
    bus.div_signed = sgn;
    bus.div_a      = a;
    bus.div_b      = b;
    exp_q.push_back(exp);
    wait_done(cyc, stall_n, seen);
    if (seen) begin
      check({name, "_done_cycle"}, 64'(cyc), 64'(exp_lat));
      check({name, "_stall_cycles"}, 64'(stall_n), 64'(exp_lat));
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  cyc;
    int  stall_n;
    bit  seen;
    total = 0;
    bad   = 0;
    fork
      monitor();
    join_none

    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_hi", {32'd0, bus.hi_o}, 64'd0);
    check("rst_lo", {32'd0, bus.lo_o}, 64'd0);
    check("rst_stall", {63'd0, bus.stall_o}, 64'd0);
    check("rst_done", {63'd0, bus.div_done}, 64'd0);
    check("rst_state", {62'd0, bus.state}, 64'd0);

    // HI/LO write, visible only the cycle after
    @(posedge clk); #1;
    bus.hilo_we = 1'b1;
    bus.hilo_i  = 64'h00000001_00000002;
    @(negedge clk);
    check("wr_no_bypass", {32'd0, bus.hi_o}, 64'd0);
    @(posedge clk); #1;
    bus.hilo_we = 1'b0;
    @(negedge clk);
    check("wr_hi", {32'd0, bus.hi_o}, 64'd1);
    check("wr_lo", {32'd0, bus.lo_o}, 64'd2);

    // MTHI-style write keeps LO
    @(posedge clk); #1;
    bus.hilo_we = 1'b1;
    bus.hilo_i  = {32'hDEADBEEF, bus.lo_o};
    @(posedge clk); #1;
    bus.hilo_we = 1'b0;
    @(negedge clk);
    check("mthi_hi", {32'd0, bus.hi_o}, 64'hDEADBEEF);
    check("mthi_lo", {32'd0, bus.lo_o}, 64'd2);

    // Asynchronous reset mid-cycle
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_hi", {32'd0, bus.hi_o}, 64'd0);
    check("arst_lo", {32'd0, bus.lo_o}, 64'd0);
    check("arst_stall", {63'd0, bus.stall_o}, 64'd0);
    check("arst_done", {63'd0, bus.div_done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Divides: name, signed, a, b, {hi,lo}, latency
    run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33);
    run_div("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},           33);
    run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33);
    run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           33);
    run_div("div_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           33);
    run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14},          33);
    run_div("divu_5_0",    1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFFFFFF},           1);
    run_div("div_m5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          {32'hFFFFFFFB, 32'hFFFFFFFF},    1);

    // ALU write in the start cycle is overwritten by the divide result
    bus.hilo_we = 1'b1;
    bus.hilo_i  = 64'h12345678_9ABCDEF0;
    run_div("we_with_start", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);

    // flush with start in IDLE: no divide, but the HI/LO write lands
    bus.hilo_we   = 1'b1;
    bus.hilo_i    = 64'h11111111_22222222;
    bus.div_start = 1'b1;
    bus.div_a     = 32'd9;
    bus.div_b     = 32'd3;
    bus.flush     = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", {63'd0, bus.stall_o}, 64'd0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("flush_idle_hi", {32'd0, bus.hi_o}, 64'h11111111);
    check("flush_idle_lo", {32'd0, bus.lo_o}, 64'h22222222);
    check("flush_idle_state", {62'd0, bus.state}, 64'd0);

    // flush in DIV cycle 10: abort, HI/LO untouched, no div_done
    @(posedge clk); #1;
    bus.div_start = 1'b1;
    bus.div_a     = 32'd100;
    bus.div_b     = 32'd7;
    repeat (10) begin
      @(posedge clk); #1;
      bus.div_start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_div_stall_c10", {63'd0, bus.stall_o}, 64'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_div_stall_after", {63'd0, bus.stall_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_div_hi", {32'd0, bus.hi_o}, 64'h11111111);
    check("flush_div_lo", {32'd0, bus.lo_o}, 64'h22222222);

    // rst in DIV cycle 20 discards the divide
    bus.div_start = 1'b1;
    bus.div_a     = 32'd100;
    bus.div_b     = 32'd7;
    repeat (20) begin
      @(posedge clk); #1;
      bus.div_start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("rst_div_hi", {32'd0, bus.hi_o}, 64'd0);
    check("rst_div_lo", {32'd0, bus.lo_o}, 64'd0);
    check("rst_div_stall", {63'd0, bus.stall_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("rst_div_hold_lo", {32'd0, bus.lo_o}, 64'd0);

    // Back-to-back: second start issued in the DONE cycle of the first
    bus.div_start  = 1'b1;
    bus.div_signed = 1'b0;
    bus.div_a      = 32'd100;
    bus.div_b      = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    wait_done(cyc, stall_n, seen);
    #1;
    bus.div_start  = 1'b1;
    bus.div_signed = 1'b1;
    bus.div_a      = 32'hFFFFFFF9;
    bus.div_b      = 32'd2;
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    #1;
    check("b2b_stall_in_done", {63'd0, bus.stall_o}, 64'd1);
    // Sampling resumes at the next negedge, so cycle 0 of the second divide is not counted.
    wait_done(cyc, stall_n, seen);
    if (seen) begin
      check("b2b_done_cycle", 64'(cyc), 64'd32);
      check("b2b_stall_cycles", 64'(stall_n), 64'd32);
    end
    @(posedge clk); #1;
    drive_idle();
    repeat (3) @(posedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
